fpmul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one single-precision floating-point multiplier (ready/done handshake, 32-bit operands and result) between N_REQ requesters. It accepts one request at a time, latches its operands, and pulses the multiplier's start strobe. It then waits for the multiplier's done pulse and returns the result to the granted requester. It sits between client datapaths and the multiplier instance; the multiplier shares this block's clock and reset.

---
 rtl/fpmul_arbiter.sv | 106 ++++++++++
 tb/tb_fpmul_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter: round-robin arbiter/sequencer sharing one FP multiplier among N_REQ requesters.
// Define FPMUL_ARB_TIMEOUT_EN to bound the WAIT state by TIMEOUT cycles with a NaN/err substitute result.
module fpmul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [32*N_REQ-1:0] req_op1,
  input  logic [32*N_REQ-1:0] req_op2,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [31:0]        rsp_res,
  output logic               rsp_err,
  output logic               busy,
  output logic               mul_ready,
  output logic [31:0]        mul_op1,
  output logic [31:0]        mul_op2,
  input  logic [31:0]        mul_res,
  input  logic               mul_done
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_last, w_gnt, w_idx;
  logic [IW:0] w_sum;
  logic [N_REQ-1:0] r_req_ready, r_rsp_valid;
  logic [31:0] r_res, r_op1, r_op2, w_op1, w_op2;
  logic r_mul_ready, w_take, w_fin, w_to;
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 8 || TIMEOUT > 255) begin : g_bad_cfg
    $error("fpmul_arbiter: parameter out of range");
  end
  // Later candidates overwrite earlier ones, so the nearest set bit after r_last wins.
  always_comb begin
    w_gnt = r_last;
    w_idx = '0;
    w_sum = '0;
    for (int k = N_REQ; k > 0; k--) begin
      w_sum = {1'b0, r_last} + (IW+1)'(k);
      w_idx = IW'(w_sum >= (IW+1)'(N_REQ) ? w_sum - (IW+1)'(N_REQ) : w_sum);
      w_gnt = req_valid[w_idx] ? w_idx : w_gnt;
    end
    w_op1 = '0;
    w_op2 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_op1 = w_gnt == IW'(i) ? req_op1[32*i +: 32] : w_op1;
      w_op2 = w_gnt == IW'(i) ? req_op2[32*i +: 32] : w_op2;
    end
  end
  assign w_take = r_state == IDLE && |req_valid;
  assign w_fin  = r_state == WAIT && (mul_done || w_to);
  always_comb begin
    w_next = r_state == IDLE  ? (w_take ? ISSUE : IDLE) :
             r_state == ISSUE ? WAIT :
             r_state == WAIT  ? (w_fin ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last      <= IW'(N_REQ - 1);
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_mul_ready <= 1'b0;
      r_res       <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
    end else begin
      r_state     <= w_next;
      r_mul_ready <= w_take;
      r_req_ready <= w_take ? N_REQ'(1) << w_gnt : '0;
      r_rsp_valid <= w_fin ? N_REQ'(1) << r_last : '0;
      if (w_take) begin
        r_op1  <= w_op1;
        r_op2  <= w_op2;
        r_last <= w_gnt;
      end
      if (w_fin) r_res <= w_to ? 32'h7FFF_FFFF : mul_res;
    end
  end
`ifdef FPMUL_ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic r_err;
  assign w_to = r_state == WAIT && !mul_done && r_cnt == 8'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= r_state == WAIT ? r_cnt + 8'd1 : 8'd0;
      if (r_state == WAIT) r_err <= w_to;
    end
  end
  assign rsp_err = r_err;
`else
  assign w_to    = 1'b0;
  assign rsp_err = 1'b0;
`endif
  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_res   = r_res;
  assign busy      = r_state != IDLE;
  assign mul_ready = r_mul_ready;
  assign mul_op1   = r_op1;
  assign mul_op2   = r_op2;
endmodule

// File: tb/tb_fpmul_arbiter.sv
// tb_fpmul_arbiter: scoreboard bench with a transaction-level arbiter model and a latency-randomised multiplier responder.
module tb_fpmul_arbiter;
  localparam int N = 4;
  localparam int TO = 16;
`ifdef FPMUL_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [32*N-1:0] req_op1 = '0;
  logic [32*N-1:0] req_op2 = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [31:0] rsp_res, mul_op1, mul_op2;
  logic [31:0] mul_res = '0;
  logic rsp_err, busy, mul_ready;
  logic mul_done = 1'b0;
  int errs = 0, checks = 0;
  bit cont = 0, autom = 0, hang = 0, stale_now = 0, stale_issue = 0, rnd_stale = 0;
  int lat_fix = 0, cnt = 0, nrsp = 0, nerr = 0;
  logic [31:0] pend;
  int obs[$];
  typedef enum {M_IDLE, M_ISSUE, M_WAIT, M_RESP} ms_t;
  ms_t ms = M_IDLE;
  int m_last = N - 1, m_g = 0, wcnt = 0;
  logic [31:0] m_op1, m_op2;
  typedef struct {int id; logic [31:0] res; logic err;} exp_t;
  exp_t expq[$];
  exp_t e;

  always #5 clk = ~clk;

  fpmul_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_res(rsp_res), .rsp_err(rsp_err),
    .busy(busy), .mul_ready(mul_ready), .mul_op1(mul_op1), .mul_op2(mul_op2),
    .mul_res(mul_res), .mul_done(mul_done)
  );

  // What the stand-in multiplier returns for a given operand pair.
  function automatic logic [31:0] resp_fn(input logic [31:0] a, input logic [31:0] b);
    return (a == 32'h4000_0000 && b == 32'h4040_0000) ? 32'h40C0_0000 : a + {b[15:0], b[31:16]};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while ((busy || |req_valid) && n < 300);
    if (busy || |req_valid) begin
      checks++;
      errs++;
      $display("FAIL wait_idle: busy=%b req_valid=%b after %0d cycles", busy, req_valid, n);
    end
  endtask

  task automatic wait_mul();
    int n;
    n = 0;
    while (!mul_ready && n < 50) begin
      cyc(1);
      n++;
    end
    if (!mul_ready) begin
      checks++;
      errs++;
      $display("FAIL wait_mul: mul_ready=%b after %0d cycles", mul_ready, n);
    end
  endtask

  // Multiplier responder: done after a 5..9 cycle latency from the start strobe, optional stale pulses.
  always @(posedge clk) begin
    #1;
    mul_done = 1'b0;
    if (rst) begin
      cnt = 0;
      stale_now = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mul_done = 1'b1;
          mul_res = pend;
        end
      end
      if ((stale_now || (rnd_stale && !busy && $urandom_range(0, 7) == 0)) && cnt == 0) begin
        mul_done = 1'b1;
        mul_res = 32'hDEAD_BEEF;
        stale_now = 0;
      end
      if (mul_ready) begin
        pend = resp_fn(mul_op1, mul_op2);
        cnt = hang ? 0 : (lat_fix != 0 ? lat_fix : int'($urandom_range(5, 9)));
        if (stale_issue || (rnd_stale && $urandom_range(0, 1) == 1)) begin
          mul_done = 1'b1;
          mul_res = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Requester behaviour: drop (or re-arm with new operands) on accept, random raise/drop in auto mode.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        if (cont) begin
          req_op1[32*i +: 32] = $urandom;
          req_op2[32*i +: 32] = $urandom;
        end else req_valid[i] = 1'b0;
      end else if (autom && !req_valid[i] && $urandom_range(0, 3) == 0) begin
        req_op1[32*i +: 32] = $urandom;
        req_op2[32*i +: 32] = $urandom;
        req_valid[i] = 1'b1;
      end else if (autom && req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
    end
  end

  // Monitor: checks every cycle against the transaction model, pops the scoreboard on each response.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ctl", {27'd0, busy, mul_ready, rsp_err, |req_ready, |rsp_valid}, 32'd0);
      chk("rst_data", rsp_res | mul_op1 | mul_op2, 32'd0);
      ms = M_IDLE;
      m_last = N - 1;
      expq.delete();
    end else begin
      chk("busy", 32'(busy), 32'(ms != M_IDLE));
      chk("req_ready", 32'(req_ready), ms == M_ISSUE ? 32'(1) << m_g : 32'd0);
      chk("mul_ready", 32'(mul_ready), 32'(ms == M_ISSUE));
      if (ms == M_ISSUE) begin
        chk("mul_op1", mul_op1, m_op1);
        chk("mul_op2", mul_op2, m_op2);
      end
      if (|req_ready) obs.push_back($clog2(req_ready));
      chk("rsp_when", 32'(|rsp_valid), 32'(ms == M_RESP));
      if (|rsp_valid) begin
        nrsp++;
        if (rsp_err) nerr++;
        if (expq.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL rsp_unexpected: rsp_valid=%b with empty scoreboard", rsp_valid);
        end else begin
          e = expq.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
          chk("rsp_res", rsp_res, e.res);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
      case (ms)
        M_IDLE: if (|req_valid) begin
          m_g = rr_pick(req_valid, m_last);
          m_last = m_g;
          m_op1 = req_op1[32*m_g +: 32];
          m_op2 = req_op2[32*m_g +: 32];
          expq.push_back('{m_g, resp_fn(m_op1, m_op2), 1'b0});
          ms = M_ISSUE;
        end
        M_ISSUE: begin
          ms = M_WAIT;
          wcnt = 0;
        end
        M_WAIT: begin
          wcnt++;
          if (mul_done) ms = M_RESP;
          else if (TO_EN && wcnt == TO) begin
            ms = M_RESP;
            if (expq.size() > 0) begin
              e = expq.pop_back();
              e.res = 32'h7FFF_FFFF;
              e.err = 1'b1;
              expq.push_back(e);
            end
          end
        end
        default: ms = M_IDLE;
      endcase
    end
  end

  initial begin
    int n0, e0, n2, k;
    cyc(3);
    rst = 1'b0;
    lat_fix = 5;
    req_op1[31:0] = 32'h4000_0000;
    req_op2[31:0] = 32'h4040_0000;
    req_valid[0] = 1'b1;
    wait_idle();
    chk("single_res", rsp_res, 32'h40C0_0000);

    rst_pulse();
    lat_fix = 0;
    obs.delete();
    for (int i = 0; i < N; i++) begin
      req_op1[32*i +: 32] = 32'h3F80_0000 + i;
      req_op2[32*i +: 32] = $urandom;
    end
    req_valid = '1;
    cont = 1;
    k = 0;
    while (obs.size() < 8 && k < 200) begin
      cyc(1);
      k++;
    end
    cont = 0;
    wait_idle();
    chk("rr_count", 32'(obs.size() >= 8), 32'd1);
    for (int i = 0; i < obs.size(); i++) chk("rr_order", obs[i], i % N);

    rst_pulse();
    stale_now = 1;
    cyc(4);
    chk("stale_idle_busy", 32'(busy), 32'd0);
    n0 = nrsp;
    stale_issue = 1;
    lat_fix = 7;
    req_op1[63:32] = 32'h4110_0000;
    req_op2[63:32] = 32'h3F00_0000;
    req_valid[1] = 1'b1;
    wait_idle();
    stale_issue = 0;
    chk("stale_rsp_count", nrsp - n0, 1);
    chk("stale_res", rsp_res, resp_fn(32'h4110_0000, 32'h3F00_0000));

    rst_pulse();
    lat_fix = 9;
    req_op1[95:64] = $urandom;
    req_valid[2] = 1'b1;
    wait_mul();
    cyc(4);
    n0 = nrsp;
    rst = 1'b1;
    req_valid = '0;
    cyc(2);
    rst = 1'b0;
    cyc(12);
    chk("abort_no_rsp", nrsp, n0);
    obs.delete();
    lat_fix = 5;
    req_valid = '1;
    k = 0;
    while (obs.size() == 0 && k < 20) begin
      cyc(1);
      k++;
    end
    chk("after_rst_grant", obs.size() > 0 ? obs[0] : -1, 0);
    wait_idle();

    rst_pulse();
    hang = 1;
    n0 = nrsp;
    e0 = nerr;
    req_valid[3] = 1'b1;
`ifdef FPMUL_ARB_TIMEOUT_EN
    k = 0;
    while (nrsp == n0 && k < 40) begin
      cyc(1);
      k++;
    end
    chk("timeout_rsp", nrsp - n0, 1);
    chk("timeout_err", nerr - e0, 1);
    chk("timeout_res", rsp_res, 32'h7FFF_FFFF);
`else
    cyc(100);
    chk("hang_no_rsp", nrsp, n0);
    chk("hang_busy", 32'(busy), 32'd1);
`endif
    hang = 0;
    rst_pulse();

    lat_fix = 9;
    obs.delete();
    req_op1[63:32] = $urandom;
    req_op1[95:64] = $urandom;
    req_valid = 4'b0110;
    wait_mul();
    cyc(2);
    req_valid[2] = 1'b0;
    cyc(25);
    n2 = 0;
    foreach (obs[i]) if (obs[i] == 2) n2++;
    chk("drop_never_granted", n2, 0);
    chk("drop_grants", obs.size(), 1);
    chk("drop_idle", 32'(busy), 32'd0);

    rst_pulse();
    lat_fix = 0;
    obs.delete();
    n0 = nrsp;
    rnd_stale = 1;
    autom = 1;
    cyc(3000);
    autom = 0;
    wait_idle();
    rnd_stale = 0;
    cyc(3);
    chk("rand_rsp_count", nrsp - n0, obs.size());
    chk("rand_scoreboard_empty", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
